// File: rtl/word_receiver_pkg.sv
// Shared definitions for the serial word receiver and its neighbours in the
// I2C/FNV datapath.
package word_receiver_pkg;

    // Width of a counter that must hold every value from 0 to width.
    function automatic int count_width(input int width);
        return $clog2(width + 1);
    endfunction

    // What the holding register does at a given edge.
    typedef enum logic [1:0] {
        HOLD_KEEP,
        HOLD_LOAD,
        HOLD_DROP,
        HOLD_CONSUME
    } hold_action_e;

endpackage

// File: rtl/word_shifter.sv
// Serial-in shift register with its own bit counter; flags the edge on which
// the final bit of a word arrives and presents that completed word.
module word_shifter
    import word_receiver_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic                          in,
    output logic [WIDTH-1:0]              word,
    output logic                          complete,
    output logic [count_width(WIDTH)-1:0] bit_count
);

    localparam int CW = count_width(WIDTH);

    logic [WIDTH-1:0] shift_q;

    // word is the register contents after absorbing the current bit, so at
    // the completion edge it is already the full word.
    generate
        if (MSB_FIRST) begin : g_msb
            assign word = {shift_q[WIDTH-2:0], in};
        end else begin : g_lsb
            assign word = {in, shift_q[WIDTH-1:1]};
        end
    endgenerate

    assign complete = enable && (bit_count == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!reset_n) begin
            shift_q   <= '0;
            bit_count <= '0;
        end else if (!enable || complete) begin
            shift_q   <= '0;
            bit_count <= '0;
        end else begin
            shift_q   <= word;
            bit_count <= bit_count + 1'b1;
        end
    end

endmodule

// File: rtl/word_receiver.sv
// Serial-to-parallel receiver: word_shifter assembles words, this level holds
// the last completed word behind a valid/ready handshake and flags overruns.
module word_receiver
    import word_receiver_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic                          in,
    output logic [WIDTH-1:0]              out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [count_width(WIDTH)-1:0] bit_count,
    output logic                          word_done,
    output logic                          overrun,
    input  logic                          clear_overrun
);

    logic [WIDTH-1:0] word;
    logic             complete;
    hold_action_e     action;

    word_shifter #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shifter (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .in        (in),
        .word      (word),
        .complete  (complete),
        .bit_count (bit_count)
    );

    always_comb begin
        // NOTE: the default assignment first keeps this block free of latches.
        action = HOLD_KEEP;
        if (complete) begin
            action = (!out_valid || out_ready) ? HOLD_LOAD : HOLD_DROP;
        end else if (out_valid && out_ready) begin
            action = HOLD_CONSUME;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            word_done <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            word_done <= complete;
            case (action)
                HOLD_LOAD: begin
                    out_data  <= word;
                    out_valid <= 1'b1;
                end
                HOLD_CONSUME: out_valid <= 1'b0;
                default: ;
            endcase
            // A drop on the same edge as a clear leaves the flag set.
            if (action == HOLD_DROP) begin
                overrun <= 1'b1;
            end else if (clear_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_word_receiver.sv
// Bench for word_receiver: three configurations share one stimulus stream and
// are compared every cycle against a bit-list model, plus literal spot checks.
module tb_word_receiver;

    localparam int NCFG = 3;
    localparam int WID  [NCFG] = '{8, 8, 16};
    localparam bit MSBF [NCFG] = '{1'b1, 1'b0, 1'b1};

    logic clk = 1'b0;
    logic reset_n, enable, in_bit, out_ready, clear_overrun;

    logic [7:0]  data_m, data_l;
    logic [15:0] data_w;
    logic [3:0]  cnt_m, cnt_l;
    logic [4:0]  cnt_w;
    logic        valid_m, valid_l, valid_w;
    logic        done_m, done_l, done_w;
    logic        over_m, over_l, over_w;

    word_receiver #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset_n(reset_n), .enable(enable), .in(in_bit),
        .out_data(data_m), .out_valid(valid_m), .out_ready(out_ready),
        .bit_count(cnt_m), .word_done(done_m), .overrun(over_m),
        .clear_overrun(clear_overrun));

    word_receiver #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset_n(reset_n), .enable(enable), .in(in_bit),
        .out_data(data_l), .out_valid(valid_l), .out_ready(out_ready),
        .bit_count(cnt_l), .word_done(done_l), .overrun(over_l),
        .clear_overrun(clear_overrun));

    word_receiver #(.WIDTH(16), .MSB_FIRST(1'b1)) dut_w (
        .clk(clk), .reset_n(reset_n), .enable(enable), .in(in_bit),
        .out_data(data_w), .out_valid(valid_w), .out_ready(out_ready),
        .bit_count(cnt_w), .word_done(done_w), .overrun(over_w),
        .clear_overrun(clear_overrun));

    always #5 clk = ~clk;

    logic [15:0] d_data  [NCFG];
    logic [4:0]  d_cnt   [NCFG];
    logic        d_valid [NCFG];
    logic        d_done  [NCFG];
    logic        d_over  [NCFG];

    assign d_data[0] = {8'h00, data_m};
    assign d_data[1] = {8'h00, data_l};
    assign d_data[2] = data_w;
    assign d_cnt[0]  = {1'b0, cnt_m};
    assign d_cnt[1]  = {1'b0, cnt_l};
    assign d_cnt[2]  = cnt_w;
    assign d_valid   = '{valid_m, valid_l, valid_w};
    assign d_done    = '{done_m, done_l, done_w};
    assign d_over    = '{over_m, over_l, over_w};

    int errors = 0;
    int checks = 0;
    bit checking = 1'b0;
    int cyc = 0;
    int done_cnt [NCFG] = '{0, 0, 0};
    int w_done_t [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: keep the list of bits received so far in the current word and
    // assemble the word from that list once it reaches the configured width.
    int          mcnt  [NCFG];
    logic        mseq  [NCFG][16];
    logic [15:0] mdata [NCFG];
    bit          mvalid[NCFG];
    bit          mover [NCFG];
    bit          mdone [NCFG];

    always @(posedge clk) begin
        logic [15:0] w;
        bit fin;
        bit drop;
        cyc++;
        for (int k = 0; k < NCFG; k++) begin
            if (!reset_n) begin
                mcnt[k] = 0; mdata[k] = '0; mvalid[k] = 0; mover[k] = 0; mdone[k] = 0;
            end else begin
                fin = 0;
                w = '0;
                if (enable) begin
                    mseq[k][mcnt[k]] = in_bit;
                    mcnt[k]++;
                    if (mcnt[k] == WID[k]) begin
                        fin = 1;
                        for (int i = 0; i < WID[k]; i++) begin
                            if (MSBF[k]) w[WID[k]-1-i] = mseq[k][i];
                            else         w[i]          = mseq[k][i];
                        end
                        mcnt[k] = 0;
                    end
                end else begin
                    mcnt[k] = 0;
                end
                drop = fin && mvalid[k] && !out_ready;
                mdone[k] = fin;
                if (fin && !drop) begin
                    mdata[k]  = w;
                    mvalid[k] = 1;
                end else if (!fin && mvalid[k] && out_ready) begin
                    mvalid[k] = 0;
                end
                if (drop) mover[k] = 1;
                else if (clear_overrun) mover[k] = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            for (int k = 0; k < NCFG; k++) begin
                check($sformatf("cfg%0d out_data", k),  d_data[k],  mdata[k]);
                check($sformatf("cfg%0d out_valid", k), d_valid[k], mvalid[k]);
                check($sformatf("cfg%0d bit_count", k), d_cnt[k],   mcnt[k]);
                check($sformatf("cfg%0d word_done", k), d_done[k],  mdone[k]);
                check($sformatf("cfg%0d overrun", k),   d_over[k],  mover[k]);
                if (d_done[k] === 1'b1) done_cnt[k]++;
            end
            if (done_w === 1'b1) w_done_t.push_back(cyc);
        end
    end

    task automatic step(input bit en, input bit b, input bit rdy, input bit clr);
        enable = en; in_bit = b; out_ready = rdy; clear_overrun = clr;
        @(posedge clk);
        #1;
    endtask

    // Sends the low n bits of data, most significant first on the wire.
    task automatic send_bits(input logic [15:0] data, input int n, input bit rdy, input bit rdy_last);
        for (int i = n - 1; i >= 0; i--) begin
            step(1'b1, data[i], (i == 0) ? rdy_last : rdy, 1'b0);
        end
    endtask

    initial begin
        int d0;
        reset_n = 1'b0; enable = 1'b0; in_bit = 1'b0; out_ready = 1'b0; clear_overrun = 1'b0;
        @(posedge clk);
        #1;
        checking = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // 1,0,1,0,0,1,0,1 then 1,1,0,0,0,0,0,0, back to back.
        send_bits(16'h00A5, 8, 1'b1, 1'b1);
        check("msb A5 data", data_m, 8'hA5);
        check("msb A5 valid", valid_m, 1'b1);
        check("msb A5 done", done_m, 1'b1);
        check("msb A5 count", cnt_m, 4'd0);
        check("lsb A5 data", data_l, 8'hA5);
        send_bits(16'h00C0, 8, 1'b1, 1'b1);
        check("lsb 03 data", data_l, 8'h03);
        check("msb C0 data", data_m, 8'hC0);
        check("w16 A5C0 data", data_w, 16'hA5C0);

        // Reset in the middle of a word.
        send_bits(16'h001F, 5, 1'b0, 1'b0);
        reset_n = 1'b0;
        step(1'b1, 1'b1, 1'b1, 1'b1);
        reset_n = 1'b1;
        check("reset data", data_m, 8'h00);
        check("reset valid", valid_m, 1'b0);
        check("reset done", done_m, 1'b0);
        check("reset count", cnt_m, 4'd0);
        check("reset overrun", over_m, 1'b0);

        // Abort after 4 bits, then a clean 3C.
        send_bits(16'h000F, 4, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        send_bits(16'h001E, 7, 1'b0, 1'b0);
        check("abort no early word", valid_m, 1'b0);
        send_bits(16'h0000, 1, 1'b0, 1'b0);
        check("abort 3C data", data_m, 8'h3C);
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // Overrun: 11 then 22 with no consumer.
        d0 = done_cnt[0];
        send_bits(16'h0011, 8, 1'b0, 1'b0);
        send_bits(16'h0022, 8, 1'b0, 1'b0);
        check("overrun data kept", data_m, 8'h11);
        check("overrun flag", over_m, 1'b1);
        check("overrun valid", valid_m, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("overrun cleared", over_m, 1'b0);
        check("overrun two pulses", done_cnt[0] - d0, 2);

        // Accept and complete on the same edge.
        send_bits(16'h0022, 8, 1'b0, 1'b1);
        check("accept+load data", data_m, 8'h22);
        check("accept+load valid", valid_m, 1'b1);
        check("accept+load overrun", over_m, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // Two back-to-back BEEF words on the 16-bit receiver.
        w_done_t.delete();
        send_bits(16'hBEEF, 16, 1'b1, 1'b1);
        send_bits(16'hBEEF, 16, 1'b1, 1'b1);
        check("w16 BEEF data", data_w, 16'hBEEF);
        check("msb last EF data", data_m, 8'hEF);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("w16 pulse count", w_done_t.size(), 2);
        if (w_done_t.size() == 2) check("w16 pulse gap", w_done_t[1] - w_done_t[0], 16);
        check("w16 no overrun", over_w, 1'b0);

        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0);
        checking = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
